// File: rtl/spi_ram_pkg.sv
// Shared command encodings and FSM state type for the SPI RAM controller.
package spi_ram_pkg;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {IDLE, TX_HOLD} state_t;
endpackage

// File: rtl/spi_ram_mem.sv
// Single-port 8-bit RAM with registered read (read-before-write on the same edge).
module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);
  logic [7:0] mem [MEM_DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/spi_ram_ctrl.sv
// RAM controller behind the SPI slave: decodes 10-bit command words into
// address loads, writes and reads. Optional SPI_RAM_WR_AUTOINC_EN bumps wr_addr after each write.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);
  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, mem_addr;
  logic [7:0]           rdata, dout_q;
  logic [1:0]           cmd;
  logic                 we;

  assign cmd      = din[9:8];
  assign we       = rx_valid && (cmd == CMD_WR_DATA);
  // Idle cycles keep rd_addr on the port so rdata stays stable during TX_HOLD.
  assign mem_addr = we ? wr_addr : rd_addr;

  spi_ram_mem #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (mem_addr),
    .wdata (din[7:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rx_valid) state_nxt = (cmd == CMD_RD_DATA) ? TX_HOLD : IDLE;
  end

  // In TX_HOLD the RAM output register is the read result; otherwise show the captured copy.
  always_comb begin
    tx_valid = (state == TX_HOLD);
    dout     = tx_valid ? rdata : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
      dout_q  <= 8'h00;
    end else if (rx_valid) begin
      if (state == TX_HOLD) dout_q <= rdata;
      case (cmd)
        CMD_WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
`ifdef SPI_RAM_WR_AUTOINC_EN
        CMD_WR_DATA: wr_addr <= wr_addr + 1'b1;
`else
        CMD_WR_DATA: ;
`endif
        CMD_RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
        default:     ;
      endcase
    end
  end
endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Single-port RAM controller sitting directly downstream of the SPI slave. It consumes the 10-bit command/data words the slave delivers on `din`/`rx_valid`, decodes the two command bits, and performs address latching, memory writes and memory reads. Read data returns to the slave on `dout`/`tx_valid` for serialisation onto MISO.

## Interface
Parameters:
- `MEM_DEPTH`, 256: number of 8-bit words; must equal 2**`ADDR_SIZE`.
- `ADDR_SIZE`, 8: address width; range 1..8.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  10  command word from the SPI slave; [9:8] is the command, [7:0] the payload.
- `rx_valid`  in  1  `din` is valid this cycle; one-cycle pulse per word.
- `dout`  out  8  read data to the SPI slave.
- `tx_valid`  out  1  `dout` is valid; held high until the next accepted word.

## Operation
- Commands: `din[9:8]` selects the operation when `rx_valid` is 1.
  - 00 WR_ADDR: `wr_addr <= din[ADDR_SIZE-1:0]`.
  - 01 WR_DATA: `mem[wr_addr] <= din[7:0]`.
  - 10 RD_ADDR: `rd_addr <= din[ADDR_SIZE-1:0]`.
  - 11 RD_DATA: `dout <= mem[rd_addr]`; `din[7:0]` is a dummy byte and is ignored.
- Payload bits above `ADDR_SIZE-1` are ignored for address commands.
- FSM states:
  - IDLE: `tx_valid`=0.
  - TX_HOLD: `tx_valid`=1.
- FSM transitions:
  - IDLE → TX_HOLD on an accepted RD_DATA.
  - TX_HOLD → TX_HOLD on another RD_DATA; `dout` reloads.
  - TX_HOLD → IDLE on any other accepted command; that command also executes in the same cycle.
  - `rx_valid`=0: state and `dout` are held.
- RD_DATA with no prior RD_ADDR since reset reads `mem[0]`.
- RD_DATA immediately after a WR_DATA to the same address returns the new value; the write completed on the previous edge.
- Memory contents are not reset. Only `wr_addr`, `rd_addr`, the FSM and the outputs are reset.

## Timing
- Reset values: `dout`=8'h00, `tx_valid`=0, state IDLE, `wr_addr`=0, `rd_addr`=0.
- Reset takes priority over `rx_valid` in the same cycle. Reset asserted during TX_HOLD drops `tx_valid` at the next edge.
- Latency: `rx_valid` with RD_DATA at edge N → `dout`/`tx_valid` valid after edge N, i.e. 1 cycle.
- Writes and address loads take effect at the edge on which `rx_valid` is sampled.
- Back-to-back `rx_valid` on consecutive cycles is legal; every word is processed, and no stall or backpressure exists.
- `tx_valid` is a level, not a pulse. The slave may sample `dout` at any time while it is high.

## Configuration
- Macro: `SPI_RAM_WR_AUTOINC_EN`.
  - Defined: each WR_DATA also performs `wr_addr <= wr_addr + 1`, wrapping from `MEM_DEPTH-1` to 0. A WR_ADDR in the same cycle cannot occur, because there is one word per cycle.
  - Undefined: `wr_addr` changes only on WR_ADDR.
- RD path is unaffected in both cases.

## Structure
- Package `spi_ram_pkg`:
  - command encodings `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11;
  - FSM state typedef (IDLE, TX_HOLD).
- Sub-module `spi_ram_mem`:
  - synchronous single-port array, 8-bit × `MEM_DEPTH`;
  - ports: `clk`, `we`, `addr`, `wdata`, `rdata`;
  - registered read.
- The controller muxes `wr_addr`/`rd_addr` onto its single address port.

## Test plan
- Reset, then RD_ADDR 10'h2_05, then RD_DATA 10'h3_00 on a never-written location → `tx_valid`=1 one cycle later; `dout` is X-free only if the memory is preloaded. Bench preloads 8'h00 and expects 8'h00.
- WR_ADDR 10'h0_3A, WR_DATA 10'h1_C5, RD_ADDR 10'h2_3A, RD_DATA → `dout`=8'hC5, `tx_valid`=1 one cycle after RD_DATA, held until the next `rx_valid`.
- Back-to-back: WR_DATA 10'h1_7E then RD_DATA on the very next cycle, with `rd_addr`=`wr_addr`=8'h10 → `dout`=8'h7E.
- While in TX_HOLD, issue WR_ADDR 10'h0_01 → `tx_valid` falls at that edge; `wr_addr`=8'h01.
- With `SPI_RAM_WR_AUTOINC_EN`: WR_ADDR 10'h0_FF, then WR_DATA 8'hAA, 8'hBB → `mem[FF]`=AA, `mem[00]`=BB (wrap). Without the macro: `mem[FF]`=BB.
- Assert `rst` for 1 cycle while in TX_HOLD with `rx_valid`=1 RD_DATA → next edge: `tx_valid`=0, `dout`=8'h00, `rd_addr`=0.
